store_buffer: RTL and testbench

Word-granular store buffer between the data-side request source (the data cache stimulus generator or the pipeline MEM stage) and the data cache port. It queues stores and drains them in order to the cache when the port is free. Loads are answered from the youngest matching buffered store or forwarded to the cache, and `requested_data_to_mem` tells the source to hold off.

---
 rtl/store_buffer.sv | 145 ++++++++++++++
 tb/tb_store_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Word-granular store buffer: queues stores in a circular FIFO, drains them in order
// to the cache, forwards loads from the youngest matching entry, and lets load misses bypass stores.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic              requested_data_to_mem,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              cache_req_read,
  output logic              cache_req_write,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic              cache_ready,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic [1:0]        dbg_state
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, LOAD = 2'd2, FLUSH = 2'd3} state_t;

  // Handshake: a request is taken on any rising edge where requested_data_to_mem is low;
  // a cache request completes on the rising edge where cache_ready is high.
  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head, tail, scan_idx;
  logic [CNT_W-1:0]  count;
  logic              load_pending, flush_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              accept, push, pop, load_acc, hit, hit_acc, miss_acc, read_done;
  logic [DATA_W-1:0] hit_data;

  assign accept    = (mem_read | mem_write) & ~requested_data_to_mem;
  assign push      = accept & mem_write;
  assign load_acc  = accept & mem_read & ~mem_write;
  assign hit_acc   = load_acc & hit;
  assign miss_acc  = load_acc & ~hit;
  assign pop       = cache_req_write & cache_ready;
  assign read_done = (state == LOAD) & cache_ready;

  // Scan oldest to youngest so the last match found is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if (CNT_W'(k) < count && addr_mem[scan_idx][ADDR_W-1:2] == address[ADDR_W-1:2]) begin
        hit      = 1'b1;
        hit_data = data_mem[scan_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A miss proved there is no alias with buffered stores, so loads go ahead of pending drains.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (load_pending | miss_acc)             next_state = LOAD;
        else if (flush | flush_req)              next_state = FLUSH;
        else if (count != '0 || push)            next_state = DRAIN;
      end
      DRAIN: begin
        if (cache_ready) begin
          if (load_pending | miss_acc)           next_state = LOAD;
          else if (flush | flush_req)            next_state = FLUSH;
          else                                   next_state = IDLE;
        end
      end
      LOAD: begin
        if (cache_ready) next_state = (flush | flush_req) ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (count == '0 || (count == CNT_W'(1) && cache_ready)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    requested_data_to_mem = (state == LOAD) | (state == FLUSH) | load_pending
                          | (count == CNT_W'(DEPTH));
    cache_req_read  = (state == LOAD);
    cache_req_write = (state == DRAIN) | ((state == FLUSH) & (count != '0));
    cache_addr      = '0;
    cache_wdata     = '0;
    if (cache_req_read) begin
      cache_addr = ld_addr;
    end else if (cache_req_write) begin
      cache_addr  = addr_mem[head];
      cache_wdata = data_mem[head];
    end
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= address;
      data_mem[tail] <= writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      load_pending <= 1'b0;
      flush_req    <= 1'b0;
      ld_addr      <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (miss_acc) ld_addr <= address;
      load_pending <= (load_pending | miss_acc) & (next_state != LOAD);
      flush_req    <= (flush_req | flush) & (next_state != FLUSH);
      rd_valid     <= hit_acc | read_done;
      if (hit_acc)        rd_data <= hit_data;
      else if (read_done) rd_data <= cache_rdata;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, forwarding, full, load bypass, flush and a reference stream.
module tb_store_buffer;
  localparam logic [1:0] S_IDLE = 2'd0, S_DRAIN = 2'd1, S_LOAD = 2'd2, S_FLUSH = 2'd3;

  logic        clk, reset, flush, mem_read, mem_write;
  logic [31:0] address, writedata;
  logic        requested_data_to_mem, rd_valid;
  logic [31:0] rd_data;
  logic        cache_req_read, cache_req_write;
  logic [31:0] cache_addr, cache_wdata;
  logic        cache_ready;
  logic [31:0] cache_rdata, rdata_reg;
  logic        rdata_auto, mon_en;
  logic [1:0]  dbg_state;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  logic [31:0] wexp_q[$];
  logic [31:0] dexp_q[$];
  logic [31:0] rexp_q[$];
  logic [31:0] mon_a, mon_d;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .writedata(writedata), .requested_data_to_mem(requested_data_to_mem),
    .rd_valid(rd_valid), .rd_data(rd_data), .cache_req_read(cache_req_read),
    .cache_req_write(cache_req_write), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_ready(cache_ready), .cache_rdata(cache_rdata), .dbg_state(dbg_state)
  );

  // Clock and reset-independent stimulus plumbing
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb cache_rdata = rdata_auto ? (cache_addr ^ 32'h5A5A_0000) : rdata_reg;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0; cache_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_unstalled();
    int n = 0;
    while (requested_data_to_mem === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("unstall", {31'b0, requested_data_to_mem}, 32'd0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; address = a; writedata = d;
    wait_unstalled();
    tick();
    mem_write = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a);
    mem_read = 1'b1; address = a;
    wait_unstalled();
    tick();
    mem_read = 1'b0;
  endtask

  function automatic logic [31:0] ref_data(input int i);
    if (i < 8)       return 32'(i + 1);
    else if (i < 16) return 32'(32'h81 + i - 8);
    else             return 32'(32'h101 + i - 16);
  endfunction

  // Scoreboard: cache transfers sampled mid-cycle against the expected queues
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (cache_req_write && cache_ready) begin
        mon_a = (wexp_q.size() > 0) ? wexp_q.pop_front() : 32'hxxxx_xxxx;
        mon_d = (dexp_q.size() > 0) ? dexp_q.pop_front() : 32'hxxxx_xxxx;
        chk("stream_wr_addr", cache_addr, mon_a);
        chk("stream_wr_data", cache_wdata, mon_d);
      end
      if (cache_req_read && cache_ready) begin
        mon_a = (rexp_q.size() > 0) ? rexp_q.pop_front() : 32'hxxxx_xxxx;
        chk("stream_rd_addr", cache_addr, mon_a);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    address = '0; writedata = '0; cache_ready = 1'b0; rdata_reg = '0;
    rdata_auto = 1'b0; mon_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_stall", {31'b0, requested_data_to_mem}, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_req_rd", {31'b0, cache_req_read}, 32'd0);
    chk("rst_req_wr", {31'b0, cache_req_write}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, S_IDLE});

    // Reset mid-drain with three entries buffered
    do_store(32'h0, 32'hA0);
    do_store(32'h4, 32'hA1);
    do_store(32'h8, 32'hA2);
    chk("mid_drain_wr", {31'b0, cache_req_write}, 32'd1);
    chk("mid_drain_addr", cache_addr, 32'h0);
    reset = 1'b1;
    #1;
    chk("async_rst_wr", {31'b0, cache_req_write}, 32'd0);
    chk("async_rst_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
    tick();
    reset = 1'b0;
    tick();
    do_load(32'h10);
    chk("post_rst_miss_rd", {31'b0, cache_req_read}, 32'd1);
    chk("post_rst_miss_addr", cache_addr, 32'h10);
    rdata_reg = 32'hDEAD_BEEF; cache_ready = 1'b1;
    tick();
    cache_ready = 1'b0;
    chk("miss_rd_valid", {31'b0, rd_valid}, 32'd1);
    chk("miss_rd_data", rd_data, 32'hDEAD_BEEF);
    tick();
    chk("miss_rd_pulse", {31'b0, rd_valid}, 32'd0);
    chk("miss_rd_hold", rd_data, 32'hDEAD_BEEF);

    // Forwarding from the youngest of two stores to one address
    do_reset();
    do_store(32'h8, 32'h1);
    do_store(32'h8, 32'h2);
    do_load(32'h8);
    chk("fwd_valid", {31'b0, rd_valid}, 32'd1);
    chk("fwd_data", rd_data, 32'h2);
    chk("fwd_no_read", {31'b0, cache_req_read}, 32'd0);
    tick();
    chk("fwd_pulse", {31'b0, rd_valid}, 32'd0);
    chk("fwd_hold", rd_data, 32'h2);
    chk("fwd_no_read2", {31'b0, cache_req_read}, 32'd0);

    // Full buffer stalls; one pop clears the stall, held store goes in after
    do_reset();
    do_store(32'h0, 32'hA0);
    do_store(32'h4, 32'hA1);
    do_store(32'h8, 32'hA2);
    do_store(32'hC, 32'hA3);
    chk("full_stall", {31'b0, requested_data_to_mem}, 32'd1);
    chk("full_head_addr", cache_addr, 32'h0);
    chk("full_head_data", cache_wdata, 32'hA0);
    mem_write = 1'b1; address = 32'h10; writedata = 32'hA4; cache_ready = 1'b1;
    tick();
    cache_ready = 1'b0;
    chk("full_pop_stall", {31'b0, requested_data_to_mem}, 32'd0);
    chk("full_pop_idle", {30'b0, dbg_state}, {30'b0, S_IDLE});
    tick();
    mem_write = 1'b0;
    chk("full_refill_stall", {31'b0, requested_data_to_mem}, 32'd1);
    chk("full_next_addr", cache_addr, 32'h4);
    chk("full_next_data", cache_wdata, 32'hA1);

    // Load miss bypasses the remaining store
    do_reset();
    do_store(32'h20, 32'hB0);
    do_store(32'h24, 32'hB1);
    do_load(32'h40);
    chk("byp_stall", {31'b0, requested_data_to_mem}, 32'd1);
    chk("byp_drain_addr", cache_addr, 32'h20);
    rdata_reg = 32'h1234_5678; cache_ready = 1'b1;
    tick();
    chk("byp_read", {31'b0, cache_req_read}, 32'd1);
    chk("byp_read_addr", cache_addr, 32'h40);
    chk("byp_no_write", {31'b0, cache_req_write}, 32'd0);
    tick();
    chk("byp_rd_valid", {31'b0, rd_valid}, 32'd1);
    chk("byp_rd_data", rd_data, 32'h1234_5678);
    tick();
    chk("byp_then_write", {31'b0, cache_req_write}, 32'd1);
    chk("byp_then_addr", cache_addr, 32'h24);
    chk("byp_then_data", cache_wdata, 32'hB1);
    tick();
    cache_ready = 1'b0;
    chk("byp_done_idle", {30'b0, dbg_state}, {30'b0, S_IDLE});

    // Flush of three entries in FIFO order
    do_reset();
    do_store(32'h30, 32'hC0);
    do_store(32'h34, 32'hC1);
    do_store(32'h38, 32'hC2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_first_addr", cache_addr, 32'h30);
    cache_ready = 1'b1;
    tick();
    chk("fl_state", {30'b0, dbg_state}, {30'b0, S_FLUSH});
    chk("fl_stall1", {31'b0, requested_data_to_mem}, 32'd1);
    chk("fl_addr2", cache_addr, 32'h34);
    tick();
    chk("fl_stall2", {31'b0, requested_data_to_mem}, 32'd1);
    chk("fl_addr3", cache_addr, 32'h38);
    chk("fl_data3", cache_wdata, 32'hC2);
    tick();
    cache_ready = 1'b0;
    chk("fl_exit_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
    chk("fl_exit_stall", {31'b0, requested_data_to_mem}, 32'd0);
    chk("fl_exit_no_wr", {31'b0, cache_req_write}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_empty_state", {30'b0, dbg_state}, {30'b0, S_FLUSH});
    tick();
    chk("fl_empty_exit", {30'b0, dbg_state}, {30'b0, S_IDLE});

    // Reference stream with cache_ready tied high
    do_reset();
    cache_ready = 1'b1; rdata_auto = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wexp_q.push_back(32'(i * 4));
      dexp_q.push_back(ref_data(i));
    end
    for (int i = 0; i < 20; i++) do_store(32'(i * 4), ref_data(i));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while ((requested_data_to_mem === 1'b1 || dbg_state !== S_IDLE) && n < 200) begin
      tick();
      n++;
    end
    chk("stream_idle", {30'b0, dbg_state}, {30'b0, S_IDLE});
    chk("stream_wr_left", 32'(wexp_q.size()), 32'd0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = (i < 4) ? 32'(32'h50 + i * 32'h20) : ((i == 4) ? 32'h0 : 32'h4C);
      rexp_q.push_back(a);
      do_load(a);
      n = 0;
      while (rd_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("stream_rd_valid", {31'b0, rd_valid}, 32'd1);
      chk("stream_rd_data", rd_data, a ^ 32'h5A5A_0000);
    end
    tick();
    chk("stream_rd_left", 32'(rexp_q.size()), 32'd0);
    mon_en = 1'b0; cache_ready = 1'b0; rdata_auto = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
